// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter joining the I$ and D$ memory ports onto one memory bus.
// An in-order master-ID FIFO steers each memory response back to its issuer.
module cache_mem_arbiter #(
  parameter int unsigned OUTSTANDING_DEPTH = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [31:0]           m0_wdata_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_error_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [31:0]           m1_wdata_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_error_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_error_i,
  output logic                  unexpected_rvalid_o
);

  localparam int unsigned PW =
    (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING_DEPTH) + 1;

  logic          id_q [OUTSTANDING_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          locked;
  logic          lock_id;
  logic          prio;
  logic          unexpected;

  logic sel;
  logic sel_valid;
  logic sel_req;
  logic full;
  logic grant;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    if (OUTSTANDING_DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    sel = 1'b0;
    sel_valid = 1'b0;
    unique case (1'b1)
      locked: begin
        sel = lock_id;
        sel_valid = 1'b1;
      end
      !locked && m0_req_i && m1_req_i: begin
        sel = prio;
        sel_valid = 1'b1;
      end
      !locked && m0_req_i && !m1_req_i: begin
        sel = 1'b0;
        sel_valid = 1'b1;
      end
      !locked && !m0_req_i && m1_req_i: begin
        sel = 1'b1;
        sel_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign full      = (count == CW'(OUTSTANDING_DEPTH));
  assign mem_req_o = rst_n & sel_valid & sel_req & ~full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign m0_gnt_o  = grant & ~sel;
  assign m1_gnt_o  = grant & sel;

  assign mem_addr_o  = !sel_valid ? '0 : (sel ? m1_addr_i : m0_addr_i);
  assign mem_wdata_o = !sel_valid ? '0 : (sel ? m1_wdata_i : m0_wdata_i);
  assign mem_we_o    = sel_valid & (sel ? m1_we_i : m0_we_i);
  assign mem_be_o    = !sel_valid ? '0 : (sel ? m1_be_i : m0_be_i);

  assign head        = id_q[rptr];
  assign pop         = rst_n & mem_rvalid_i & (count != '0);
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
  assign m0_error_o  = m0_rvalid_o & mem_error_i;
  assign m1_error_o  = m1_rvalid_o & mem_error_i;

  assign unexpected_rvalid_o = unexpected;

  always_ff @(posedge clk) begin
    if (grant) id_q[wptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      locked     <= 1'b0;
      lock_id    <= 1'b0;
      prio       <= 1'b0;
      unexpected <= 1'b0;
    end else begin
      if (grant) begin
        wptr   <= nxt(wptr);
        prio   <= ~sel;
        locked <= 1'b0;
      end else if (mem_req_o) begin
        // hold this request phase until the memory accepts it
        locked  <= 1'b1;
        lock_id <= sel;
      end
      if (pop) rptr <= nxt(rptr);
      unique case ({grant, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (mem_rvalid_i && count == '0) unexpected <= 1'b1;
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Two-master to one-slave arbiter on the memory side of the cache layer. Master 0 is the instruction cache's memory port and master 1 is the data cache's memory port; the slave is the shared memory bus.
- Speaks the same req/gnt/rvalid protocol on all three sides.
- Arbitration is round-robin with a lock on each granted request phase.
- Multiple transactions may be outstanding; a master-ID FIFO routes each rvalid back to the master that issued the request.

Parameters:
- OUTSTANDING_DEPTH, 2: maximum granted-but-not-yet-rvalid transactions. Power of two, ≥1.
- ADDR_WIDTH, 32: address width on all ports.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  master request address
- m0_wdata_i / m1_wdata_i  in  32  master write data
- m0_we_i / m1_we_i  in  1  master write enable
- m0_be_i / m1_be_i  in  4  master byte enables
- m0_req_i / m1_req_i  in  1  master request
- m0_gnt_o / m1_gnt_o  out  1  master grant
- m0_rvalid_o / m1_rvalid_o  out  1  response valid
- m0_rdata_o / m1_rdata_o  out  32  response data
- m0_error_o / m1_error_o  out  1  response error
- mem_addr_o  out  ADDR_WIDTH  selected address
- mem_wdata_o  out  32  selected write data
- mem_we_o  out  1  selected write enable
- mem_be_o  out  4  selected byte enables
- mem_req_o  out  1  request to memory
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data
- mem_error_i  in  1  memory error
- unexpected_rvalid_o  out  1  sticky flag: rvalid received with ID FIFO empty

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - ID FIFO emptied (count=0); lock cleared; priority pointer = m0; unexpected_rvalid_o=0.
  - While rst_n=0, all gnt, rvalid and mem_req_o outputs are forced to 0.
  - Reset mid-transaction discards all outstanding IDs; later mem_rvalid_i pulses set unexpected_rvalid_o.
- Selection (combinational from registered state plus requests):
  - If locked: select lock_id.
  - Else if only one master requests: select that master.
  - Else if both request: select the master not granted last, per the priority pointer.
- mem_req_o = selected master's req AND FIFO not full. mem_addr/wdata/we/be mux from the selected master; all zero when nothing is selected.
- gnt routing: m*_gnt_o = mem_gnt_i AND mem_req_o AND (selected == m*). Zero latency, same cycle.
- Lock:
  - Set with lock_id=sel when mem_req_o=1 and mem_gnt_i=0. The request phase is never switched until granted.
  - Cleared on the grant cycle.
  - Masters hold their request stable until granted, so the lock is guaranteed to resolve.
- On grant: push the selected ID to the FIFO, priority pointer = other master, lock cleared.
- Response routing:
  - On mem_rvalid_i with FIFO non-empty: pop the head ID. Assert m{head}_rvalid_o=1 and drive rdata and error from memory, same cycle, combinational.
  - The non-addressed master sees rvalid=0; its rdata and error hold 0.
- Simultaneous grant and rvalid: push and pop in the same cycle; count is unchanged and ordering is preserved.
- FIFO full (count == OUTSTANDING_DEPTH):
  - mem_req_o=0 and no grant; the lock is not set.
  - A pop in that same cycle does not enable a grant; the grant becomes possible from the next cycle.
- mem_rvalid_i with FIFO empty: no master rvalid; unexpected_rvalid_o set to 1 until reset.
- Count arithmetic: width $clog2(OUTSTANDING_DEPTH)+1; read/write pointers wrap modulo depth.
- Responses are returned strictly in grant order; memory is required to be in-order.

Test Plan:
- Single master:
  - Stimulus: m0 read, addr 0x100, gnt in the same cycle, rvalid 1 cycle later, rdata 0xDEADBEEF.
  - Required: m0_gnt_o same cycle; m0_rvalid_o with 0xDEADBEEF; m1 outputs all 0.
- Contention:
  - Stimulus: m0 and m1 request in the same cycle, repeated 4 times back to back after reset.
  - Required: grant order m0, m1, m0, m1.
- Lock:
  - Stimulus: m1 requests alone, mem_gnt_i held 0 for 3 cycles; m0 requests from cycle 1.
  - Required: mem_addr_o stays m1's address until granted; m0 is granted next.
- Depth limit (OUTSTANDING_DEPTH=2):
  - Stimulus: 3 grants requested with no rvalid.
  - Required: mem_req_o=0 on the 3rd request.
  - Follow-up: one rvalid, then the 3rd request is granted the following cycle; response order matches grant order.
- Simultaneous push/pop:
  - Stimulus: rvalid for m0 in the same cycle as m1 is granted.
  - Required: m0_rvalid_o=1; next rvalid routes to m1; count unchanged.
- Errors and reset:
  - Stimulus: mem_error_i=1 on an m1 response.
    Required: m1_error_o=1.
  - Stimulus: rvalid when the FIFO is empty.
    Required: unexpected_rvalid_o=1, held until rst_n=0.
  - Stimulus: rst_n=0 with 2 transactions outstanding.
    Required: count=0 and pointer=m0 next cycle.
